// File: rtl/text_vram_reader_pkg.sv
// Shared constants and types for the text-mode VRAM reader: screen geometry,
// control-word colour fields and the RGB444 pixel type.
package text_vram_reader_pkg;

    localparam int H_CHARS_DEF = 80;
    localparam int V_CHARS_DEF = 30;
    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;

    localparam logic [10:0] CTRL_ADDR  = 11'd600;
    localparam logic [31:0] CTRL_RESET = 32'h01FF_E000;

    localparam int FG_LSB   = 13;
    localparam int BG_LSB   = 1;
    localparam int COLOUR_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        rgb444_t fg;
        rgb444_t bg;
    } palette_t;

    function automatic palette_t palette_of(input logic [31:0] ctrl);
        palette_t p;
        p.fg = rgb444_t'(ctrl[FG_LSB +: COLOUR_W]);
        p.bg = rgb444_t'(ctrl[BG_LSB +: COLOUR_W]);
        return p;
    endfunction

endpackage

// File: rtl/text_vram_reader_if.sv
// Video-side bundle of the reader: raster timing in, VRAM port B, font ROM,
// and the delayed pixel/sync stream out to the HDMI encoder.
interface text_vram_reader_if;

    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic        vde;
    logic        hsync_in;
    logic        vsync_in;
    logic [31:0] control_in;

    logic [10:0] addrb;
    logic        enb;
    logic [31:0] doutb;

    logic [10:0] font_addr;
    logic [7:0]  font_data;

    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync_out;
    logic        vsync_out;
    logic        vde_out;

    modport master (
        input  drawX, drawY, vde, hsync_in, vsync_in, control_in, doutb, font_data,
        output addrb, enb, font_addr, red, green, blue, hsync_out, vsync_out, vde_out
    );

    modport slave (
        output drawX, drawY, vde, hsync_in, vsync_in, control_in, doutb, font_data,
        input  addrb, enb, font_addr, red, green, blue, hsync_out, vsync_out, vde_out
    );

endinterface

// File: rtl/text_vram_reader_sig_delay.sv
// Fixed-length shift-register delay used to carry sideband fields alongside
// the VRAM/font pipeline.
module sig_delay #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [N-1:0][W-1:0] stage_q;

    // NOTE: every stage is reset so no stale syncs or vde leak out after reset;
    // a pure data delay line could skip this and map to SRL primitives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/text_vram_reader.sv
// Raster-order text renderer: fetches character codes from VRAM port B, looks
// up glyph rows in the font ROM and emits per-pixel RGB444 with aligned syncs.
module text_vram_reader
    import text_vram_reader_pkg::*;
#(
    parameter int H_CHARS  = H_CHARS_DEF,
    parameter int V_CHARS  = V_CHARS_DEF,
    parameter int BRAM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    text_vram_reader_if.master  vid
);

    localparam int XS = $clog2(GLYPH_W);
    localparam int YS = $clog2(GLYPH_H);

    // S0: character index and VRAM word address straight from the raster position
    logic [12:0] char_idx;
    logic [10:0] word_addr;
    logic [10:0] addr_hold_q;

    assign char_idx  = 13'(vid.drawY[9:YS]) * 13'(H_CHARS) + 13'(vid.drawX[9:XS]);
    assign word_addr = char_idx[12:2];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_hold_q <= '0;
        end else if (vid.vde) begin
            addr_hold_q <= word_addr;
        end
    end

    assign vid.addrb = reset ? '0 : (vid.vde ? word_addr : addr_hold_q);
    assign vid.enb   = vid.vde & ~reset;

    // Sidebands that must meet doutb when it returns from the BRAM
    logic [8:0] side_s1;
    logic [1:0] byte_sel_s1;
    logic [2:0] col_s1;
    logic [3:0] row_s1;

    sig_delay #(.W(9), .N(BRAM_LAT)) u_side_s1 (
        .clk   (clk),
        .reset (reset),
        .d_i   ({char_idx[1:0], vid.drawX[2:0], vid.drawY[3:0]}),
        .q_o   (side_s1)
    );

    assign byte_sel_s1 = side_s1[8:7];
    assign col_s1      = side_s1[6:4];
    assign row_s1      = side_s1[3:0];

    // Timing sidebands stop one stage short; the output register adds the last cycle
    logic [2:0] sync_s2;
    logic       vde_s2;
    logic       hsync_s2;
    logic       vsync_s2;

    sig_delay #(.W(3), .N(BRAM_LAT + 1)) u_sync_s2 (
        .clk   (clk),
        .reset (reset),
        .d_i   ({vid.vde, vid.hsync_in, vid.vsync_in}),
        .q_o   (sync_s2)
    );

    assign {vde_s2, hsync_s2, vsync_s2} = sync_s2;

    // S1: byte pick, inverse-video flag and font lookup
    logic [7:0] byte_s1;
    logic       inv_s1;

    assign byte_s1       = vid.doutb[{byte_sel_s1, 3'b000} +: 8];
    assign inv_s1        = byte_s1[7];
    assign vid.font_addr = {byte_s1[6:0], row_s1};

    // Palette shadow reloads only on a vsync rise so a frame never changes colour mid-scan
    logic     vsync_q;
    palette_t palette_q;
    palette_t palette_d;

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        palette_d = palette_q;
        if (vid.vsync_in && !vsync_q) begin
            palette_d = palette_of(vid.control_in);
        end
    end

    logic    pix_q;
    rgb444_t rgb_q;
    logic    hsync_q;
    logic    vsync_out_q;
    logic    vde_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q     <= 1'b0;
            palette_q   <= palette_of(CTRL_RESET);
            pix_q       <= 1'b0;
            rgb_q       <= '0;
            hsync_q     <= 1'b0;
            vsync_out_q <= 1'b0;
            vde_q       <= 1'b0;
        end else begin
            vsync_q     <= vid.vsync_in;
            palette_q   <= palette_d;
            pix_q       <= vid.font_data[3'd7 - col_s1] ^ inv_s1;
            rgb_q       <= vde_s2 ? (pix_q ? palette_q.fg : palette_q.bg) : '0;
            hsync_q     <= hsync_s2;
            vsync_out_q <= vsync_s2;
            vde_q       <= vde_s2;
        end
    end

    assign vid.red       = rgb_q.r;
    assign vid.green     = rgb_q.g;
    assign vid.blue      = rgb_q.b;
    assign vid.hsync_out = hsync_q;
    assign vid.vsync_out = vsync_out_q;
    assign vid.vde_out   = vde_q;

    logic ctrl_unused;
    assign ctrl_unused = ^{vid.control_in[31:25], vid.control_in[0]};

    // Active video must stay inside the character grid and away from the control word
    assert property (@(posedge clk) disable iff (reset)
        vid.vde |-> (vid.addrb != CTRL_ADDR) && (int'(vid.drawY[9:YS]) < V_CHARS));

endmodule

// File: tb/tb_text_vram_reader.sv
// Randomised raster stimulus against a pixel-level reference model of the
// text renderer, plus directed reset, latency, inversion and palette cases.
module tb_text_vram_reader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    text_vram_reader_if vid ();

    text_vram_reader dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vid)
    );

    logic [31:0] vram [2048];
    logic [7:0]  font [2048];

    // Read-first BRAM port B with one cycle of latency, combinational font ROM
    always @(posedge clk) begin
        if (vid.enb) vid.doutb <= vram[vid.addrb];
    end

    assign vid.font_data = font[vid.font_addr];

    typedef struct {
        logic [11:0] rgb;
        logic [2:0]  sy;
    } exp_t;

    exp_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] shadow;
    logic        prev_vs;
    logic [10:0] last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pixel colour straight from the character/glyph rules
    function automatic logic [11:0] model_rgb(input int x, input int y, input bit v,
                                              input logic [31:0] sh);
        int idx;
        int b;
        int bitv;
        if (!v) return 12'h000;
        idx  = (y / 16) * 80 + x / 8;
        b    = int'((vram[idx / 4] >> (8 * (idx % 4))) & 32'hFF);
        bitv = int'((font[(b % 128) * 16 + y % 16] >> (7 - x % 8)) & 8'h01);
        bitv = bitv ^ (b / 128);
        return (bitv != 0) ? sh[24:13] : sh[12:1];
    endfunction

    task automatic step(input int x, input int y, input bit v, input bit hs, input bit vs);
        exp_t e;
        vid.drawX    = 10'(x);
        vid.drawY    = 10'(y);
        vid.vde      = v;
        vid.hsync_in = hs;
        vid.vsync_in = vs;
        if (vs && !prev_vs) shadow = vid.control_in;
        prev_vs = vs;
        #1;
        if (v) last_addr = 11'(((y / 16) * 80 + x / 8) / 4);
        check("enb", {31'd0, vid.enb}, {31'd0, v});
        check("addrb", {21'd0, vid.addrb}, {21'd0, last_addr});
        e.rgb = model_rgb(x, y, v, shadow);
        e.sy  = {hs, vs, v};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            check("rgb", {20'd0, vid.red, vid.green, vid.blue}, {20'd0, e.rgb});
            check("sync", {29'd0, vid.hsync_out, vid.vsync_out, vid.vde_out}, {29'd0, e.sy});
        end
    endtask

    task automatic flush();
        repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vsync_burst();
        repeat (2) step(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(0, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        exp_t z;
        reset = 1'b1;
        #1;
        check("rst_rgb", {20'd0, vid.red, vid.green, vid.blue}, 32'd0);
        check("rst_vde", {31'd0, vid.vde_out}, 32'd0);
        check("rst_addrb", {21'd0, vid.addrb}, 32'd0);
        check("rst_enb", {31'd0, vid.enb}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_q.delete();
        z.rgb     = 12'h000;
        z.sy      = 3'b000;
        exp_q.push_back(z);
        exp_q.push_back(z);
        last_addr = '0;
        shadow    = 32'h01FF_E000;
        prev_vs   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            vram[i] = $urandom;
            font[i] = 8'($urandom);
        end
        vram[0]         = 32'h0000_0041;
        font[16'h41*16] = 8'h80;
        vram[5]         = 32'hC100_0000;
        vid.doutb       = '0;
        vid.control_in  = 32'h01FF_E000;
        vid.drawX       = '0;
        vid.drawY       = '0;
        vid.vde         = 1'b0;
        vid.hsync_in    = 1'b0;
        vid.vsync_in    = 1'b0;
        prev_vs         = 1'b0;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 'A' at the top-left cell: leftmost pixel foreground, next background
        step(0, 0, 1'b1, 1'b0, 1'b0);
        step(1, 0, 1'b1, 1'b0, 1'b0);
        flush();

        // Byte 3 of word 5 carries the inverse-video flag
        step(23 * 8, 0, 1'b1, 1'b0, 1'b0);
        check("font_addr", {21'd0, vid.font_addr}, 32'h0000_0410);
        flush();

        // Bottom-right cell is the last text word
        step(639, 479, 1'b1, 1'b0, 1'b0);
        check("last_word", {21'd0, vid.addrb}, 32'd599);
        flush();

        // Mid-frame control write must wait for the next vsync rise
        vid.control_in = 32'h0000_1FFE;
        for (int i = 0; i < 24; i++) step(i, 0, 1'b1, 1'b0, 1'b0);
        vsync_burst();
        for (int i = 0; i < 24; i++) step(i, 0, 1'b1, 1'b0, 1'b0);
        flush();

        // Randomised raster with blanking, hsync, frame boundaries and a reset
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) vsync_burst();
            if (i % 97 == 0) vid.control_in = $urandom;
            if (i == 700) do_reset();
            step(int'($urandom_range(639)), int'($urandom_range(479)),
                 ($urandom_range(3) != 0), 1'($urandom), 1'b0);
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
